// File: rtl/adaptive_binarize_pkg.sv
// Shared widths, divider state encoding and threshold clamp for the adaptive binarizer.
package adaptive_binarize_pkg;

  localparam int SUM_W = 32;
  localparam int CNT_W = 20;
  localparam int REM_W = 28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Saturate a biased mean back into the 8-bit gray range.
  function automatic logic [7:0] clamp_u8(input logic signed [9:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 10'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/serial_mean_div.sv
// Restoring serial divider producing an 8-bit mean (sum / cnt), one quotient bit per cycle, MSB first.
module serial_mean_div
  import adaptive_binarize_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [SUM_W-1:0] sum_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       quot_o
);

  div_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       quot_q, quot_d;
  logic [REM_W-1:0] trial;
  logic             unused_sum_hi;

  // The mean never exceeds 255, so the sum always fits in the remainder width.
  assign unused_sum_hi = ^sum_i[SUM_W-1:REM_W];
  assign trial         = REM_W'(cnt_q) << bit_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    quot_d  = quot_q;
    unique case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        rem_d   = sum_i[REM_W-1:0];
        cnt_d   = cnt_i;
        bit_d   = 3'd7;
        quot_d  = '0;
        state_d = (cnt_i == '0) ? S_IDLE : S_DIV;
      end
      S_DIV: begin
        if (rem_q >= trial) begin
          rem_d         = rem_q - trial;
          quot_d[bit_q] = 1'b1;
        end
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A fresh snapshot always wins, aborting any division in flight.
    if (start_i)
      state_d = S_LOAD;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      quot_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      quot_q  <= quot_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign quot_o = quot_q;

endmodule

// File: rtl/adaptive_binarize.sv
// Binarizes a gray pixel stream against the previous frame's mean plus an offset,
// keeping sync and row/column counters aligned with the one-cycle pixel latency.
module adaptive_binarize
  import adaptive_binarize_pkg::*;
#(
  parameter int                W        = 32,
  parameter int                H        = 32,
  parameter logic [7:0]        INIT_THR = 8'd128,
  parameter logic signed [8:0] OFFSET   = 9'sd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  input  logic        hs,
  input  logic [7:0]  data,
  input  logic [10:0] hang_cnt_out,
  input  logic [10:0] lie_cnt_out,
  output logic        fs_o,
  output logic        hs_o,
  output logic [7:0]  data_o,
  output logic [10:0] hang_cnt_o,
  output logic [10:0] lie_cnt_o,
  output logic [7:0]  thr_o,
  output logic        thr_valid_o
);

  localparam int PIX_MAX = (1 << CNT_W) - 1;

  if (W * H > PIX_MAX) begin : g_bad_size
    $error("adaptive_binarize: W*H exceeds the pixel counter range");
  end

  logic [SUM_W-1:0] sum_q, sum_d, snap_sum_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_cnt_q;
  logic             start_q;
  logic             fs_q, hs_q;
  logic [7:0]       data_q, data_d;
  logic [10:0]      hang_q, lie_q;
  logic [7:0]       thr_q, thr_apply;
  logic [7:0]       thr_next_q, thr_next_d;
  logic             pix_v, fs_fall, fs_rise;
  logic             div_done, unused_div_busy;
  logic [7:0]       quot;
  logic signed [9:0] biased;

  assign pix_v   = fs & hs;
  assign fs_fall = fs_q & ~fs;
  assign fs_rise = fs & ~fs_q;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (fs_fall) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (pix_v) begin
      sum_d = sum_q + SUM_W'(data);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  serial_mean_div u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_q),
    .sum_i   (snap_sum_q),
    .cnt_i   (snap_cnt_q),
    .busy_o  (unused_div_busy),
    .done_o  (div_done),
    .quot_o  (quot)
  );

  assign biased     = $signed({2'b00, quot}) + 10'(OFFSET);
  assign thr_next_d = div_done ? clamp_u8(biased) : thr_next_q;
  // Bypass lets a result finishing in the same cycle as fs rises still reach that frame.
  assign thr_apply  = fs_rise ? thr_next_d : thr_q;
  assign data_d     = (pix_v && (data >= thr_apply)) ? 8'hFF : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      snap_sum_q <= '0;
      snap_cnt_q <= '0;
      start_q    <= 1'b0;
      fs_q       <= 1'b0;
      hs_q       <= 1'b0;
      data_q     <= '0;
      hang_q     <= '0;
      lie_q      <= '0;
      thr_q      <= INIT_THR;
      thr_next_q <= INIT_THR;
    end else begin
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      start_q    <= fs_fall;
      if (fs_fall) begin
        snap_sum_q <= sum_q;
        snap_cnt_q <= cnt_q;
      end
      fs_q       <= fs;
      hs_q       <= hs;
      data_q     <= data_d;
      hang_q     <= hang_cnt_out;
      lie_q      <= lie_cnt_out;
      thr_q      <= thr_apply;
      thr_next_q <= thr_next_d;
    end
  end

  assign fs_o        = fs_q;
  assign hs_o        = hs_q;
  assign data_o      = data_q;
  assign hang_cnt_o  = hang_q;
  assign lie_cnt_o   = lie_q;
  assign thr_o       = thr_q;
  assign thr_valid_o = div_done;

endmodule
